multicycle_control: RTL and testbench

Multicycle sequencer for the LEGv8 datapath. Once per instruction it fetches, decodes the 11-bit opcode, selects the immediate format on `SignOp` for SignExtender's `Ctrl` input, and steps the datapath through EXEC/MEM/WB. It stalls on a memory ready handshake and traps on illegal opcodes. It sits between instruction memory/IR and the register file, ALU, SignExtender and data memory.

---
 rtl/multicycle_control.sv | 151 +++++++++++++++
 tb/tb_multicycle_control.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: LEGv8 multicycle sequencer (fetch/decode/exec/mem/wb, memory-ready stalls, illegal-opcode trap)
// Ports: CLK, Reset_L (sync active-low); Opcode = IR[31:21]; Zero = ALU flag used by CBZ; MemReady = memory access done.
//        SignOp/ALUOp/ALUSrc/Reg2Loc steer the datapath; MemRead/MemWrite/IRWrite/PCWrite/PCSrc/RegWrite/MemToReg are
//        datapath strobes and selects; InstrDone pulses on the last cycle of an instruction; Trap is sticky until reset;
//        State exposes the sequencer state for debug.
module multicycle_control (
    input  logic        CLK,
    input  logic        Reset_L,
    input  logic [10:0] Opcode,
    input  logic        Zero,
    input  logic        MemReady,
    output logic [2:0]  SignOp,
    output logic [3:0]  ALUOp,
    output logic        ALUSrc,
    output logic        Reg2Loc,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic        RegWrite,
    output logic        MemToReg,
    output logic        InstrDone,
    output logic        Trap,
    output logic [2:0]  State
);
    typedef enum logic [2:0] {
        FETCH  = 3'b000,
        DECODE = 3'b001,
        EXEC   = 3'b010,
        MEM    = 3'b011,
        WB     = 3'b100,
        TRAP   = 3'b111
    } state_t;
    typedef enum logic [2:0] {C_R, C_I, C_LD, C_ST, C_B, C_CB, C_MZ} cls_t;

    state_t     state;
    cls_t       cls, dec_cls;
    logic [3:0] op, dec_op;
    logic       dec_ok;
    logic       mem_read, mem_write, ir_write, pc_write, reg_write, done;

    function automatic logic [2:0] fmt(input cls_t c);
        case (c)
            C_LD, C_ST: fmt = 3'b001;
            C_B:        fmt = 3'b010;
            C_CB:       fmt = 3'b011;
            C_MZ:       fmt = 3'b100;
            default:    fmt = 3'b000;
        endcase
    endfunction

    // op carries the EXEC/MEM ALU operation for every class, so MEM can hold it without re-decoding
    always_comb begin
        dec_ok  = 1'b1;
        dec_cls = C_R;
        dec_op  = 4'b0000;
        casez (Opcode)
            11'b10001011000: dec_op = 4'b0010;
            11'b11001011000: dec_op = 4'b0110;
            11'b10001010000: dec_op = 4'b0000;
            11'b10101010000: dec_op = 4'b0001;
            11'b1001000100?: begin dec_cls = C_I;  dec_op = 4'b0010; end
            11'b1101000100?: begin dec_cls = C_I;  dec_op = 4'b0110; end
            11'b11111000010: begin dec_cls = C_LD; dec_op = 4'b0010; end
            11'b11111000000: begin dec_cls = C_ST; dec_op = 4'b0010; end
            11'b000101?????: dec_cls = C_B;
            11'b10110100???: begin dec_cls = C_CB; dec_op = 4'b0111; end
            11'b110100101??: begin dec_cls = C_MZ; dec_op = 4'b0111; end
            default:         dec_ok = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            state <= FETCH;
            cls   <= C_R;
            op    <= 4'b0000;
        end else begin
            case (state)
                FETCH:  if (MemReady) state <= DECODE;
                DECODE: begin
                    state <= dec_ok ? EXEC : TRAP;
                    if (dec_ok) begin
                        cls <= dec_cls;
                        op  <= dec_op;
                    end
                end
                EXEC:   state <= (cls == C_B || cls == C_CB) ? FETCH : (cls == C_LD || cls == C_ST) ? MEM : WB;
                MEM:    if (MemReady) state <= (cls == C_LD) ? WB : FETCH;
                WB:     state <= FETCH;
                default: state <= TRAP;
            endcase
        end
    end

    always_comb begin
        SignOp    = 3'b000;
        ALUOp     = 4'b0000;
        ALUSrc    = 1'b0;
        Reg2Loc   = 1'b0;
        PCSrc     = 1'b0;
        MemToReg  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        done      = 1'b0;
        case (state)
            FETCH: begin
                mem_read = 1'b1;
                ir_write = MemReady;
                pc_write = MemReady;
            end
            DECODE: SignOp = fmt(dec_cls);
            EXEC: begin
                SignOp   = fmt(cls);
                ALUOp    = op;
                ALUSrc   = cls inside {C_I, C_LD, C_ST, C_MZ};
                Reg2Loc  = cls inside {C_ST, C_CB};
                pc_write = cls == C_B || (cls == C_CB && Zero);
                PCSrc    = cls == C_B || (cls == C_CB && Zero);
                done     = cls inside {C_B, C_CB};
            end
            MEM: begin
                SignOp    = fmt(cls);
                ALUOp     = op;
                mem_read  = cls == C_LD;
                mem_write = cls == C_ST;
                done      = cls == C_ST && MemReady;
            end
            WB: begin
                reg_write = 1'b1;
                MemToReg  = cls == C_LD;
                done      = 1'b1;
            end
            default: ;
        endcase
    end

    // strobes are gated combinationally so nothing fires during the reset cycle itself
    assign MemRead   = Reset_L & mem_read;
    assign MemWrite  = Reset_L & mem_write;
    assign IRWrite   = Reset_L & ir_write;
    assign PCWrite   = Reset_L & pc_write;
    assign RegWrite  = Reset_L & reg_write;
    assign InstrDone = Reset_L & done;
    assign Trap      = state == TRAP;
    assign State     = state;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: instruction-level reference model driving and checking multicycle_control every cycle
module tb_multicycle_control;
    logic        CLK, Reset_L, Zero, MemReady;
    logic [10:0] Opcode;
    logic [2:0]  SignOp, State;
    logic [3:0]  ALUOp;
    logic        ALUSrc, Reg2Loc, MemRead, MemWrite, IRWrite, PCWrite, PCSrc, RegWrite, MemToReg, InstrDone, Trap;

    multicycle_control dut (
        .CLK(CLK), .Reset_L(Reset_L), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .SignOp(SignOp), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .Reg2Loc(Reg2Loc),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
        .RegWrite(RegWrite), .MemToReg(MemToReg), .InstrDone(InstrDone), .Trap(Trap), .State(State)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    localparam int K_ILL = 0, K_R = 1, K_I = 2, K_LD = 3, K_ST = 4, K_B = 5, K_CB = 6, K_MZ = 7;
    localparam logic [10:0] F_SRC = 11'h400, F_R2L = 11'h200, F_MRD = 11'h100, F_MWR = 11'h080,
                            F_IRW = 11'h040, F_PCW = 11'h020, F_PCS = 11'h010, F_RW = 11'h008,
                            F_M2R = 11'h004, F_DN = 11'h002, F_TR = 11'h001;
    localparam logic [20:0] STROBES = {10'd0, F_MRD | F_MWR | F_IRW | F_PCW | F_RW | F_DN};
    localparam logic [10:0] OP_ADD = 11'b10001011000, OP_SUB = 11'b11001011000, OP_AND = 11'b10001010000,
                            OP_ORR = 11'b10101010000, OP_LDUR = 11'b11111000010, OP_STUR = 11'b11111000000,
                            OP_CBZ = 11'b10110100000, OP_MOVZ = 11'b11010010100, OP_B = 11'b00010100000;

    typedef struct {
        logic        rl, mr, z;
        logic [10:0] opc;
        logic [20:0] exp;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   passes = 0;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [10:0] rop();
        return 11'($urandom());
    endfunction

    function automatic ent_t ent(input logic rl, input logic mr, input logic z, input logic [10:0] opc, input logic [20:0] exp);
        ent_t e;
        e.rl = rl;
        e.mr = mr;
        e.z = z;
        e.opc = opc;
        e.exp = exp;
        return e;
    endfunction

    function automatic logic [20:0] mk(input logic [2:0] st, input logic [2:0] so, input logic [3:0] ao, input logic [10:0] f);
        return {st, so, ao, f};
    endfunction

    function automatic int cls_of(input logic [10:0] o);
        if (o == OP_ADD || o == OP_SUB || o == OP_AND || o == OP_ORR) return K_R;
        if (o ==? 11'b1001000100? || o ==? 11'b1101000100?) return K_I;
        if (o == OP_LDUR) return K_LD;
        if (o == OP_STUR) return K_ST;
        if (o[10:5] == 6'b000101) return K_B;
        if (o[10:3] == 8'b10110100) return K_CB;
        if (o[10:2] == 9'b110100101) return K_MZ;
        return K_ILL;
    endfunction

    function automatic logic [2:0] fmt_of(input int k);
        if (k == K_LD || k == K_ST) return 3'b001;
        if (k == K_B) return 3'b010;
        if (k == K_CB) return 3'b011;
        if (k == K_MZ) return 3'b100;
        return 3'b000;
    endfunction

    function automatic void exec_of(input int k, input logic [10:0] o, input logic z,
                                    output logic [2:0] so, output logic [3:0] ao, output logic [10:0] f);
        so = fmt_of(k);
        ao = 4'b0010;
        f  = F_SRC;
        case (k)
            K_R: begin
                ao = (o == OP_ADD) ? 4'b0010 : (o == OP_SUB) ? 4'b0110 : (o == OP_ORR) ? 4'b0001 : 4'b0000;
                f  = 11'd0;
            end
            K_I:  ao = o[9] ? 4'b0110 : 4'b0010;
            K_ST: f = F_SRC | F_R2L;
            K_MZ: ao = 4'b0111;
            K_B: begin
                ao = 4'b0000;
                f  = F_PCW | F_PCS | F_DN;
            end
            K_CB: begin
                ao = 4'b0111;
                f  = F_R2L | F_DN | (z ? (F_PCW | F_PCS) : 11'd0);
            end
            default: ;
        endcase
    endfunction

    function automatic logic [10:0] rand_legal();
        logic [10:0] r;
        r = rop();
        case ($urandom_range(0, 9))
            0: return OP_ADD;
            1: return OP_SUB;
            2: return OP_AND;
            3: return OP_ORR;
            4: return {9'b100100010, rb() ? 1'b1 : 1'b0, r[0]} ^ {1'b0, r[1], 9'd0} & 11'h7FF;
            5: return OP_LDUR;
            6: return OP_STUR;
            7: return {6'b000101, r[4:0]};
            8: return {8'b10110100, r[2:0]};
            default: return {9'b110100101, r[1:0]};
        endcase
    endfunction

    // expands one instruction into its expected per-cycle inputs and outputs; cut >= 0 drops Reset_L on that cycle
    task automatic add_instr(input logic [10:0] opc, input int nf, input int nm, input logic z, input int cut, input int nt);
        ent_t t[$];
        ent_t e;
        int k;
        logic [2:0] so;
        logic [3:0] ao;
        logic [10:0] f;
        k = cls_of(opc);
        for (int i = 0; i < nf; i++) t.push_back(ent(1'b1, 1'b0, rb(), rop(), mk(3'd0, 3'd0, 4'd0, F_MRD)));
        t.push_back(ent(1'b1, 1'b1, rb(), rop(), mk(3'd0, 3'd0, 4'd0, F_MRD | F_IRW | F_PCW)));
        t.push_back(ent(1'b1, rb(), rb(), opc, mk(3'd1, fmt_of(k), 4'd0, 11'd0)));
        if (k == K_ILL) begin
            for (int i = 0; i < nt; i++) t.push_back(ent(1'b1, rb(), rb(), opc, mk(3'd7, 3'd0, 4'd0, F_TR)));
            t.push_back(ent(1'b0, rb(), rb(), opc, mk(3'd7, 3'd0, 4'd0, F_TR)));
        end else begin
            exec_of(k, opc, z, so, ao, f);
            t.push_back(ent(1'b1, rb(), z, opc, mk(3'd2, so, ao, f)));
            if (k == K_LD || k == K_ST) begin
                for (int i = 0; i < nm; i++)
                    t.push_back(ent(1'b1, 1'b0, rb(), opc, mk(3'd3, so, ao, (k == K_LD) ? F_MRD : F_MWR)));
                t.push_back(ent(1'b1, 1'b1, rb(), opc, mk(3'd3, so, ao, (k == K_LD) ? F_MRD : (F_MWR | F_DN))));
            end
            if (k != K_B && k != K_CB && k != K_ST)
                t.push_back(ent(1'b1, rb(), rb(), opc, mk(3'd4, 3'd0, 4'd0, F_RW | F_DN | ((k == K_LD) ? F_M2R : 11'd0))));
            if (cut >= 0 && cut < t.size()) begin
                e = t[cut];
                e.rl = 1'b0;
                e.exp = e.exp & ~STROBES;
                t[cut] = e;
                while (t.size() > cut + 1) void'(t.pop_back());
            end
        end
        foreach (t[i]) q.push_back(t[i]);
    endtask

    task automatic run(output int done_at);
        ent_t e;
        logic [20:0] act;
        int n;
        n = 0;
        done_at = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge CLK);
            Reset_L = e.rl;
            MemReady = e.mr;
            Zero = e.z;
            Opcode = e.opc;
            #1;
            n++;
            act = {State, SignOp, ALUOp, ALUSrc, Reg2Loc, MemRead, MemWrite, IRWrite, PCWrite, PCSrc,
                   RegWrite, MemToReg, InstrDone, Trap};
            checks++;
            if (act === e.exp) passes++;
            else $display("FAIL outs t=%0t opcode=%b: got %h expected %h", $time, e.opc, act, e.exp);
            if (InstrDone === 1'b1 && done_at == 0) done_at = n;
        end
    endtask

    task automatic chk(input string nm, input int a, input int b);
        checks++;
        if (a == b) passes++;
        else $display("FAIL %s: got %0d expected %0d", nm, a, b);
    endtask

    initial begin
        int d;
        int nf, nm, cut;
        logic [10:0] opc;
        Reset_L = 1'b0;
        MemReady = 1'b0;
        Zero = 1'b0;
        Opcode = 11'd0;
        @(posedge CLK);
        q.push_back(ent(1'b0, rb(), rb(), rop(), 21'd0));
        run(d);
        add_instr(OP_ADD, 0, 0, 1'b0, -1, 0);
        chk("add_len", q.size(), 4);
        run(d);
        chk("add_done", d, 4);
        add_instr(OP_LDUR, 0, 2, 1'b0, -1, 0);
        chk("ld_len", q.size(), 7);
        run(d);
        chk("ld_done", d, 7);
        add_instr(OP_CBZ, 0, 0, 1'b1, -1, 0);
        run(d);
        chk("cbz1_done", d, 3);
        add_instr(OP_CBZ | 11'd5, 0, 0, 1'b0, -1, 0);
        run(d);
        chk("cbz0_done", d, 3);
        add_instr(OP_MOVZ, 0, 0, 1'b0, -1, 0);
        run(d);
        chk("movz_done", d, 4);
        add_instr(OP_B, 0, 0, 1'b0, -1, 0);
        chk("b_len", q.size(), 3);
        run(d);
        chk("b_done", d, 3);
        add_instr(11'd0, 0, 0, 1'b0, -1, 10);
        chk("trap_len", q.size(), 13);
        run(d);
        chk("trap_done", d, 0);
        add_instr(OP_STUR, 0, 3, 1'b0, 4, 0);
        chk("st_len", q.size(), 5);
        run(d);
        chk("st_done", d, 0);
        for (int i = 0; i < 400; i++) begin
            opc = ($urandom_range(0, 6) == 0) ? rop() : rand_legal();
            nf  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            nm  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            cut = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : -1;
            add_instr(opc, nf, nm, rb(), cut, $urandom_range(1, 3));
            run(d);
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
